// File: rtl/matrix_scan_if.sv
// Game-state inputs and matrix pin outputs of the LED-matrix scan driver.
// Pure wiring bundle, no storage; the scan driver samples inputs once per row slot.
// No handshake: inputs are levels, outputs are registered pin drives.
interface matrix_scan_if;
    logic [63:0] wall_map;   // bit r*8+c set = wall at row r, column c
    logic [2:0]  pos_row;
    logic [2:0]  pos_col;
    logic [2:0]  goal_row;
    logic [2:0]  goal_col;
    logic        arrived;    // level, high while the player sits on the goal
    logic [7:0]  row;        // active-low row select
    logic [7:0]  g_col;      // active-high green column drive
    logic [7:0]  r_col;      // active-high red column drive

    // Game side: owns the board state, observes the pins.
    modport master (
        output wall_map, pos_row, pos_col, goal_row, goal_col, arrived,
        input  row, g_col, r_col
    );

    // Scan driver side: samples the board state, drives the pins.
    modport slave (
        input  wall_map, pos_row, pos_col, goal_row, goal_col, arrived,
        output row, g_col, r_col
    );
endinterface

// File: rtl/matrix_scan.sv
// Time-multiplexes the maze (walls red, player green, goal amber, arrival blink) onto an 8x8 bicolour matrix.
// Latency: inputs sampled once per TICK_DIV-cycle slot; a change shows when its row is next scanned (<= 8*TICK_DIV cycles).
// No backpressure: free-running scan, inputs are levels and all outputs are registers.
module matrix_scan #(
    parameter int TICK_DIV    = 50000,  // clk cycles per row slot, >= 2
    parameter int BLINK_TICKS = 250     // row slots per blink half-period, >= 1
) (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active-low
    matrix_scan_if.slave scan
);

    localparam int DW = $clog2(TICK_DIV);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic [DW-1:0] div_cnt_q,   div_cnt_d;
    logic [2:0]    ridx_q,      ridx_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q,     phase_d;
    logic [7:0]    row_q,       row_d;
    logic [7:0]    g_col_q,     g_col_d;
    logic [7:0]    r_col_q,     r_col_d;

    logic          tick;
    logic [7:0]    wall_row;
    logic [7:0]    goal_bit;
    logic [7:0]    pos_bit;

    assign tick     = (div_cnt_q == DIV_LAST);
    assign wall_row = scan.wall_map[{ridx_q, 3'b000} +: 8];
    assign goal_bit = 8'b1 << scan.goal_col;
    assign pos_bit  = 8'b1 << scan.pos_col;

    // Next-state: prescaler always runs; row, colours and blink state only move on tick.
    always_comb begin
        div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
        ridx_d      = ridx_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        row_d       = row_q;
        g_col_d     = g_col_q;
        r_col_d     = r_col_q;

        if (tick) begin
            ridx_d = ridx_q + 3'd1;  // 3-bit wrap 7 -> 0
            row_d  = ~(8'b1 << ridx_q);

            if (scan.arrived) begin
                // Whole board flashes green; the load uses the phase held
                // before this tick, so a fresh arrival always starts lit.
                g_col_d = phase_q ? 8'h00 : 8'hFF;
                r_col_d = 8'h00;
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d = '0;
                    phase_d     = ~phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end else begin
                blink_cnt_d = '0;
                phase_d     = 1'b0;
                r_col_d     = wall_row;
                g_col_d     = 8'h00;
                if (scan.goal_row == ridx_q) begin
                    r_col_d = r_col_d | goal_bit;
                    g_col_d = g_col_d | goal_bit;
                end
                // Player is applied last so it wins over both wall and goal.
                if (scan.pos_row == ridx_q) begin
                    g_col_d = g_col_d | pos_bit;
                    r_col_d = r_col_d & ~pos_bit;
                end
            end
        end
    end

    // State and output registers; reset blanks the board immediately and restarts at row 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q   <= '0;
            ridx_q      <= 3'd0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            row_q       <= 8'hFF;
            g_col_q     <= 8'h00;
            r_col_q     <= 8'h00;
        end else begin
            div_cnt_q   <= div_cnt_d;
            ridx_q      <= ridx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            row_q       <= row_d;
            g_col_q     <= g_col_d;
            r_col_q     <= r_col_d;
        end
    end

    assign scan.row   = row_q;
    assign scan.g_col = g_col_q;
    assign scan.r_col = r_col_q;

endmodule
